// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the G-15 run/halt sequencer.
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    HALT = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2
  } run_state_t;

  typedef enum logic [1:0] {
    NO_GO = 2'd0,
    GO    = 2'd1,
    BP    = 2'd2
  } sw_pos_t;

  localparam int unsigned DEBOUNCE_DEFAULT = 32'd4096;

  // Map the debounced contacts to a switch position. With no contact made,
  // the switch is between detents, so the previous position is kept. Any
  // contact combination that is not one-hot is treated as NO_GO.
  function automatic sw_pos_t decode_pos(input logic go, input logic no_go,
                                         input logic bp, input sw_pos_t prev);
    sw_pos_t pos;
    case ({go, no_go, bp})
      3'b100:  pos = GO;
      3'b010:  pos = NO_GO;
      3'b001:  pos = BP;
      3'b000:  pos = prev;
      default: pos = NO_GO;
    endcase
    return pos;
  endfunction

endpackage

// File: rtl/switch_debounce.sv
// Two-flop synchronizer followed by a stability counter for one raw contact.
// level_o is the accepted level as it will be after the coming edge, so the
// parent can register decisions on it in the same cycle the level flips.
module switch_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 32'd4096
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic level_o
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 32'd1);

  logic             sync1_q;
  logic             sync2_q;
  logic             level_q;
  logic             level_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Count consecutive cycles the synchronized input disagrees with the
  // accepted level; any agreement (a glitch ending) restarts the count.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 32'd1)) begin
        level_d = sync2_q;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  // Synchronizer, counter and accepted level.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_d;

endmodule

// File: rtl/compute_switch_ctrl.sv
// Run/halt sequencer: conditions the compute switch and STEP button and
// grants CPU_GO. Starts align to T0; halts land on a rising edge of RC.
module compute_switch_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic       CLOCK,
  input  logic       rst,
  input  logic       T0,
  input  logic       SW_GO,
  input  logic       SW_NO_GO,
  input  logic       SW_BP,
  input  logic       MP_STEP,
  input  logic       RC,
  input  logic       CMD_BP,
  input  logic       HALT_CMD,
  output logic       CPU_GO,
  output logic       HALTED,
  output logic       BP_HIT,
  output logic       STEP_ACTIVE,
  output logic [1:0] SW_POS
);

  logic       go_lvl, no_go_lvl, bp_lvl, step_lvl;
  run_state_t state_q, state_d;
  sw_pos_t    sw_pos_q, sw_pos_d;
  logic       start_pend_q, start_pend_d;
  logic       step_pend_q, step_pend_d;
  logic       halt_lat_q, halt_lat_d;
  logic       step_first_q, step_first_d;
  logic       bp_hit_q, bp_hit_d;
  logic       step_prev_q, rc_q;
  logic       cpu_go_q, halted_q, step_active_q;
  logic       start_evt, step_evt, rc_rise, halt_seen;

  switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_go (
    .clk_i(CLOCK), .rst_ni(rst), .raw_i(SW_GO), .level_o(go_lvl));
  switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_no_go (
    .clk_i(CLOCK), .rst_ni(rst), .raw_i(SW_NO_GO), .level_o(no_go_lvl));
  switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_bp (
    .clk_i(CLOCK), .rst_ni(rst), .raw_i(SW_BP), .level_o(bp_lvl));
  switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_step (
    .clk_i(CLOCK), .rst_ni(rst), .raw_i(MP_STEP), .level_o(step_lvl));

  // Event detection and next-state logic for the run/halt FSM.
  always_comb begin
    sw_pos_d   = decode_pos(go_lvl, no_go_lvl, bp_lvl, sw_pos_q);
    start_evt  = (sw_pos_d != sw_pos_q) && ((sw_pos_d == GO) || (sw_pos_d == BP));
    step_evt   = step_lvl && !step_prev_q && (state_q == HALT) && (sw_pos_q == NO_GO);
    rc_rise    = RC && !rc_q;
    halt_seen  = halt_lat_q || HALT_CMD;

    state_d      = state_q;
    bp_hit_d     = bp_hit_q;
    step_first_d = step_first_q;
    halt_lat_d   = rc_rise ? 1'b0 : halt_seen;
    // A start event outranks a simultaneous step request.
    start_pend_d = start_pend_q || start_evt;
    step_pend_d  = start_evt ? 1'b0 : (step_pend_q || step_evt);

    case (state_q)
      HALT: begin
        halt_lat_d = 1'b0;
        if (T0 && start_pend_q) begin
          state_d      = RUN;
          start_pend_d = 1'b0;
          step_pend_d  = 1'b0;
          bp_hit_d     = 1'b0;
        end else if (T0 && step_pend_q) begin
          state_d      = STEP;
          step_pend_d  = 1'b0;
          bp_hit_d     = 1'b0;
          step_first_d = 1'b0;
        end else begin
          state_d = HALT;
        end
      end
      RUN: begin
        // Starts arriving while running are discarded, so holding GO
        // after a halt cannot restart the CPU.
        start_pend_d = 1'b0;
        step_pend_d  = 1'b0;
        if (rc_rise) begin
          if (sw_pos_q == NO_GO) begin
            state_d = HALT;
          end else if (halt_seen) begin
            state_d = HALT;
          end else if ((sw_pos_q == BP) && CMD_BP) begin
            state_d  = HALT;
            bp_hit_d = 1'b1;
          end else begin
            state_d = RUN;
          end
        end else begin
          state_d = RUN;
        end
      end
      STEP: begin
        start_pend_d = 1'b0;
        step_pend_d  = 1'b0;
        // The first boundary is the one that began the step.
        if (rc_rise) begin
          if (step_first_q || halt_seen) begin
            state_d = HALT;
          end else begin
            step_first_d = 1'b1;
          end
        end else begin
          state_d = STEP;
        end
      end
      default: begin
        state_d = HALT;
      end
    endcase
  end

  // State, pending flags and registered outputs.
  always_ff @(posedge CLOCK or negedge rst) begin
    if (!rst) begin
      state_q       <= HALT;
      sw_pos_q      <= NO_GO;
      start_pend_q  <= 1'b0;
      step_pend_q   <= 1'b0;
      halt_lat_q    <= 1'b0;
      step_first_q  <= 1'b0;
      bp_hit_q      <= 1'b0;
      step_prev_q   <= 1'b0;
      rc_q          <= 1'b0;
      cpu_go_q      <= 1'b0;
      halted_q      <= 1'b1;
      step_active_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sw_pos_q      <= sw_pos_d;
      start_pend_q  <= start_pend_d;
      step_pend_q   <= step_pend_d;
      halt_lat_q    <= halt_lat_d;
      step_first_q  <= step_first_d;
      bp_hit_q      <= bp_hit_d;
      step_prev_q   <= step_lvl;
      rc_q          <= RC;
      cpu_go_q      <= (state_d != HALT);
      halted_q      <= (state_d == HALT);
      step_active_q <= (state_d == STEP);
    end
  end

  assign CPU_GO      = cpu_go_q;
  assign HALTED      = halted_q;
  assign BP_HIT      = bp_hit_q;
  assign STEP_ACTIVE = step_active_q;
  assign SW_POS      = sw_pos_q;

endmodule

// File: tb/tb_compute_switch_ctrl.sv
// Scoreboard bench for compute_switch_ctrl with DEBOUNCE_CYCLES=4 and a
// T0 strobe every 29 clocks. Stimulus queues expected output snapshots; a
// monitor compares them on the falling edge.
module tb_compute_switch_ctrl;

  logic       CLOCK, rst, T0;
  logic       SW_GO, SW_NO_GO, SW_BP, MP_STEP, RC, CMD_BP, HALT_CMD;
  logic       CPU_GO, HALTED, BP_HIT, STEP_ACTIVE;
  logic [1:0] SW_POS;

  typedef struct {
    string      name;
    logic       go;
    logic       halted;
    logic       bp;
    logic       step;
    logic [1:0] pos;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   checks;
  int   errors;
  int   tc;

  compute_switch_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
    .CLOCK(CLOCK), .rst(rst), .T0(T0),
    .SW_GO(SW_GO), .SW_NO_GO(SW_NO_GO), .SW_BP(SW_BP), .MP_STEP(MP_STEP),
    .RC(RC), .CMD_BP(CMD_BP), .HALT_CMD(HALT_CMD),
    .CPU_GO(CPU_GO), .HALTED(HALTED), .BP_HIT(BP_HIT),
    .STEP_ACTIVE(STEP_ACTIVE), .SW_POS(SW_POS)
  );

  initial begin
    CLOCK = 1'b0;
    forever #5 CLOCK = ~CLOCK;
  end

  // Free-running word-time strobe, one clock wide every 29 clocks.
  initial begin
    T0 = 1'b0;
    tc = 0;
    forever begin
      @(posedge CLOCK);
      #1;
      tc = (tc == 28) ? 0 : tc + 1;
      T0 = (tc == 0);
    end
  end

  // Monitor: compare every queued expectation against the outputs.
  always @(negedge CLOCK) begin
    while (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      checks++;
      if ({CPU_GO, HALTED, BP_HIT, STEP_ACTIVE, SW_POS} !==
          {cur.go, cur.halted, cur.bp, cur.step, cur.pos}) begin
        errors++;
        $display("FAIL %s: got go=%b halted=%b bp_hit=%b step=%b pos=%0d, want go=%b halted=%b bp_hit=%b step=%b pos=%0d",
                 cur.name, CPU_GO, HALTED, BP_HIT, STEP_ACTIVE, SW_POS,
                 cur.go, cur.halted, cur.bp, cur.step, cur.pos);
      end
    end
  end

  task automatic expect_st(input string name, input logic go, input logic halted,
                           input logic bp, input logic step, input logic [1:0] pos);
    exp_t e;
    e.name = name; e.go = go; e.halted = halted; e.bp = bp; e.step = step; e.pos = pos;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLOCK);
    #1;
  endtask

  // Return just after the edge that consumed the next T0 strobe.
  task automatic wait_t0();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(posedge CLOCK);
      if (T0) found = 1'b1;
    end
    #1;
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL wait_t0: got no T0 in 40 cycles, want one");
    end
  endtask

  task automatic set_sw(input logic go, input logic no_go, input logic bp);
    SW_GO = go; SW_NO_GO = no_go; SW_BP = bp;
  endtask

  task automatic rc_pulse(input logic cmd_bp);
    RC = 1'b1; CMD_BP = cmd_bp;
    tick(1);
    RC = 1'b0; CMD_BP = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b0; RC = 1'b0; CMD_BP = 1'b0; HALT_CMD = 1'b0; MP_STEP = 1'b0;
    set_sw(1'b0, 1'b1, 1'b0);

    // 1. Reset state
    tick(3);
    expect_st("reset", 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    tick(1);
    rst = 1'b1;
    tick(12);
    expect_st("post_reset", 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);

    // 2. NO_GO -> GO: 6-cycle debounce, start at T0, halt on NO_GO boundary
    wait_t0();
    set_sw(1'b1, 1'b0, 1'b0);
    tick(5);
    expect_st("deb_5cyc", 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    tick(1);
    expect_st("deb_6cyc", 1'b0, 1'b1, 1'b0, 1'b0, 2'd1);
    tick(14);
    expect_st("wait_for_t0", 1'b0, 1'b1, 1'b0, 1'b0, 2'd1);
    wait_t0();
    expect_st("run_after_t0", 1'b1, 1'b0, 1'b0, 1'b0, 2'd1);
    rc_pulse(1'b0);
    expect_st("rc_go_runs", 1'b1, 1'b0, 1'b0, 1'b0, 2'd1);
    set_sw(1'b0, 1'b1, 1'b0);
    tick(8);
    expect_st("nogo_waits_boundary", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    RC = 1'b1;
    expect_st("rc_cycle_still_go", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    tick(1);
    RC = 1'b0;
    expect_st("nogo_halt", 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);

    // 3. Breakpoint position
    wait_t0();
    set_sw(1'b0, 1'b0, 1'b1);
    tick(8);
    expect_st("bp_pos", 1'b0, 1'b1, 1'b0, 1'b0, 2'd2);
    wait_t0();
    expect_st("bp_run", 1'b1, 1'b0, 1'b0, 1'b0, 2'd2);
    rc_pulse(1'b0);
    expect_st("bp_no_flag", 1'b1, 1'b0, 1'b0, 1'b0, 2'd2);
    tick(2);
    rc_pulse(1'b1);
    expect_st("bp_halt", 1'b0, 1'b1, 1'b1, 1'b0, 2'd2);
    wait_t0();
    set_sw(1'b0, 1'b1, 1'b0);
    tick(8);
    expect_st("bp_hold_nogo", 1'b0, 1'b1, 1'b1, 1'b0, 2'd0);
    set_sw(1'b0, 1'b0, 1'b1);
    tick(8);
    expect_st("bp_rearm", 1'b0, 1'b1, 1'b1, 1'b0, 2'd2);
    wait_t0();
    expect_st("bp_restart", 1'b1, 1'b0, 1'b0, 1'b0, 2'd2);
    set_sw(1'b0, 1'b1, 1'b0);
    tick(8);
    HALT_CMD = 1'b1;
    tick(1);
    HALT_CMD = 1'b0;
    tick(2);
    rc_pulse(1'b1);
    expect_st("multi_halt_no_bp", 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);

    // 4. Single step
    wait_t0();
    MP_STEP = 1'b1;
    tick(8);
    expect_st("step_pending", 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    MP_STEP = 1'b0;
    wait_t0();
    expect_st("step_active", 1'b1, 1'b0, 1'b0, 1'b1, 2'd0);
    rc_pulse(1'b0);
    expect_st("step_first_rc", 1'b1, 1'b0, 1'b0, 1'b1, 2'd0);
    tick(3);
    rc_pulse(1'b0);
    expect_st("step_done", 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    wait_t0();
    set_sw(1'b1, 1'b0, 1'b0);
    tick(8);
    wait_t0();
    expect_st("run2", 1'b1, 1'b0, 1'b0, 1'b0, 2'd1);
    MP_STEP = 1'b1;
    tick(8);
    MP_STEP = 1'b0;
    tick(8);
    expect_st("step_in_run_ignored", 1'b1, 1'b0, 1'b0, 1'b0, 2'd1);
    rc_pulse(1'b0);
    expect_st("step_in_run_rc", 1'b1, 1'b0, 1'b0, 1'b0, 2'd1);

    // 6. HALT_CMD, no restart while GO is held, restart after cycling
    HALT_CMD = 1'b1;
    tick(1);
    HALT_CMD = 1'b0;
    tick(3);
    expect_st("halt_cmd_waits", 1'b1, 1'b0, 1'b0, 1'b0, 2'd1);
    rc_pulse(1'b0);
    expect_st("halt_cmd_halt", 1'b0, 1'b1, 1'b0, 1'b0, 2'd1);
    wait_t0();
    wait_t0();
    expect_st("hold_go_no_restart", 1'b0, 1'b1, 1'b0, 1'b0, 2'd1);
    set_sw(1'b0, 1'b1, 1'b0);
    tick(8);
    set_sw(1'b1, 1'b0, 1'b0);
    tick(8);
    expect_st("go_recycled", 1'b0, 1'b1, 1'b0, 1'b0, 2'd1);
    wait_t0();
    expect_st("go_restart", 1'b1, 1'b0, 1'b0, 1'b0, 2'd1);
    set_sw(1'b0, 1'b1, 1'b0);
    tick(8);
    rc_pulse(1'b0);
    expect_st("halt_for_bounce", 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);

    // 5. Contact bounce and illegal contact combination
    wait_t0();
    SW_NO_GO = 1'b0;
    for (int i = 0; i < 14; i++) begin
      SW_GO = ~SW_GO;
      tick(3);
      if (i == 7) expect_st("bounce_mid", 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    end
    SW_GO = 1'b0;
    tick(6);
    expect_st("bounce_pos", 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    wait_t0();
    expect_st("bounce_no_start", 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    set_sw(1'b1, 1'b0, 1'b1);
    tick(8);
    expect_st("go_bp_both", 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    wait_t0();
    expect_st("both_no_start", 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    set_sw(1'b1, 1'b0, 1'b0);
    tick(8);
    expect_st("go_from_both", 1'b0, 1'b1, 1'b0, 1'b0, 2'd1);
    wait_t0();
    expect_st("run3", 1'b1, 1'b0, 1'b0, 1'b0, 2'd1);

    // 1b. Asynchronous reset while running
    tick(2);
    rst = 1'b0;
    expect_st("async_reset_run", 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    tick(2);
    rst = 1'b1;
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
